// File: rtl/ws2811_serializer.sv
// ws2811_serializer: shifts 24-bit colour words MSB-first onto a WS2811
// data line as duty-coded bits, requests one word per LED from the
// upstream provider and closes each frame with a latch (reset) period.
//
// Handshake with the provider: there is no valid/ready pair. The provider
// must hold a valid word on rgb at all times. rgb is sampled only on a
// capture edge. The cycle after each capture edge advance is high for
// exactly one cycle, meaning "word taken, present the next one". The
// provider then has one full LED time to update rgb before the next
// capture.
module ws2811_serializer #(
  parameter int NUM_LEDS     = 200,
  parameter int BIT_PERIOD   = 63,
  parameter int T0H          = 13,
  parameter int T1H          = 30,
  parameter int RESET_CYCLES = 2600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] rgb,
  output logic        advance,
  output logic        serial_reset,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  // Each counter is just wide enough for its terminal value.
  localparam int PW = $clog2(BIT_PERIOD);
  localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(BIT_PERIOD - 1);
  localparam logic [PW-1:0] T0H_W      = PW'(T0H);
  localparam logic [PW-1:0] T1H_W      = PW'(T1H);
  localparam logic [LW-1:0] LED_LAST   = LW'(NUM_LEDS - 1);
  localparam logic [RW-1:0] LATCH_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [4:0]    BIT_LAST   = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [23:0]   shift, shift_n;
  logic [4:0]    bit_idx, bit_idx_n;
  logic [PW-1:0] phase, phase_n;
  logic [LW-1:0] led_cnt, led_cnt_n;
  logic [RW-1:0] latch_cnt, latch_cnt_n;
  logic          capture;

  logic dout_n, advance_n, serial_reset_n, busy_n, frame_done_n;

  // Next-state logic: bit/phase/LED sequencing, latch timing, word capture.
  always_comb begin
    state_n     = state;
    shift_n     = shift;
    bit_idx_n   = bit_idx;
    phase_n     = phase;
    led_cnt_n   = led_cnt;
    latch_cnt_n = latch_cnt;
    capture     = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          state_n   = SEND;
          capture   = 1'b1;
          led_cnt_n = '0;
        end
      end
      SEND: begin
        if (phase == PHASE_LAST) begin
          if (bit_idx == BIT_LAST) begin
            if (led_cnt == LED_LAST) begin
              state_n     = LATCH;
              latch_cnt_n = '0;
            end else begin
              led_cnt_n = led_cnt + 1'b1;
              capture   = 1'b1;
            end
          end else begin
            shift_n   = {shift[22:0], 1'b0};
            bit_idx_n = bit_idx + 1'b1;
            phase_n   = '0;
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      LATCH: begin
        // enable only matters here, at the end of the latch period.
        if (latch_cnt == LATCH_LAST) begin
          if (enable) begin
            state_n   = SEND;
            capture   = 1'b1;
            led_cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          latch_cnt_n = latch_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A capture loads the next word and restarts the bit timing, so the
    // first high cycle of its MSB follows the capture edge directly.
    if (capture) begin
      shift_n   = rgb;
      bit_idx_n = '0;
      phase_n   = '0;
    end
  end

  // Output values for the next cycle, derived from the next state so every
  // output can be registered without an extra cycle of latency.
  always_comb begin
    dout_n         = (state_n == SEND) &&
                     (phase_n < (shift_n[23] ? T1H_W : T0H_W));
    advance_n      = capture;
    serial_reset_n = (state_n == LATCH);
    frame_done_n   = (state_n == LATCH) && (latch_cnt_n == LATCH_LAST);
    busy_n         = (state_n != IDLE);
  end

  // State, counters and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      shift        <= '0;
      bit_idx      <= '0;
      phase        <= '0;
      led_cnt      <= '0;
      latch_cnt    <= '0;
      dout         <= 1'b0;
      advance      <= 1'b0;
      serial_reset <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      shift        <= shift_n;
      bit_idx      <= bit_idx_n;
      phase        <= phase_n;
      led_cnt      <= led_cnt_n;
      latch_cnt    <= latch_cnt_n;
      dout         <= dout_n;
      advance      <= advance_n;
      serial_reset <= serial_reset_n;
      busy         <= busy_n;
      frame_done   <= frame_done_n;
    end
  end

endmodule
